// File: rtl/game_pkg.sv
// Shared definitions for the binary number game: round FSM states, LFSR taps and default sizes.
package game_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 4;
    localparam int unsigned DEFAULT_ROUNDS = 8;
    localparam logic [7:0]  LFSR_TAPS      = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_CHECK,
        ST_RESULT,
        ST_DONE
    } game_state_e;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 8-bit Galois LFSR; advances every cycle and exposes its low OUT_W bits.
module game_lfsr
    import game_pkg::*;
#(
    parameter logic [7:0]  SEED  = 8'hA5,
    parameter int unsigned OUT_W = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] value_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/binary_game_ctrl.sv
// Round controller for the binary number game: target generation, guess capture, scoring.
// Optional per-guess timeout is built when GAME_TIMEOUT_EN is defined (adds timeout_o).
module binary_game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned ROUNDS = DEFAULT_ROUNDS,
    parameter logic [7:0]  SEED   = 8'hA5
`ifdef GAME_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         submit_i,
    input  logic [WIDTH-1:0]             guess_i,
    input  logic                         cmp_match_i,
    output logic [WIDTH-1:0]             cmp_num_1_o,
    output logic [WIDTH-1:0]             cmp_num_2_o,
    output logic [WIDTH-1:0]             target_o,
    output logic                         busy_o,
    output logic                         hit_o,
    output logic                         miss_o,
    output logic [$clog2(ROUNDS+1)-1:0]  score_o,
    output logic [$clog2(ROUNDS+1)-1:0]  round_o,
    output logic                         game_over_o
`ifdef GAME_TIMEOUT_EN
    ,
    output logic                         timeout_o
`endif
);

    localparam int unsigned CW = $clog2(ROUNDS + 1);

    game_state_e      state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic             match_q, match_d;
    logic [CW-1:0]    score_q, score_d;
    logic [CW-1:0]    round_q, round_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic [WIDTH-1:0] lfsr_bits;

`ifdef GAME_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] timer_q, timer_d;
    logic          expired_q, expired_d;
    logic          timeout_q, timeout_d;
`endif

    game_lfsr #(
        .SEED  (SEED),
        .OUT_W (WIDTH)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_o (lfsr_bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            guess_q   <= '0;
            match_q   <= 1'b0;
            score_q   <= '0;
            round_q   <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
`ifdef GAME_TIMEOUT_EN
            timer_q   <= '0;
            expired_q <= 1'b0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            guess_q   <= guess_d;
            match_q   <= match_d;
            score_q   <= score_d;
            round_q   <= round_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
`ifdef GAME_TIMEOUT_EN
            timer_q   <= timer_d;
            expired_q <= expired_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        guess_d   = guess_q;
        match_d   = match_q;
        score_d   = score_q;
        round_d   = round_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
`ifdef GAME_TIMEOUT_EN
        timer_d   = timer_q;
        expired_d = expired_q;
        timeout_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    score_d = '0;
                    round_d = '0;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                target_d  = lfsr_bits;
                state_d   = ST_WAIT;
`ifdef GAME_TIMEOUT_EN
                timer_d   = '0;
                expired_d = 1'b0;
`endif
            end

            ST_WAIT: begin
                if (submit_i) begin
                    guess_d = guess_i;
                    state_d = ST_CHECK;
`ifdef GAME_TIMEOUT_EN
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    // Expiry skips the compare; a cleared match forces the miss.
                    match_d   = 1'b0;
                    expired_d = 1'b1;
                    state_d   = ST_RESULT;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end

            ST_CHECK: begin
                match_d = cmp_match_i;
                state_d = ST_RESULT;
            end

            ST_RESULT: begin
                hit_d   = match_q;
                miss_d  = !match_q;
`ifdef GAME_TIMEOUT_EN
                timeout_d = expired_q;
`endif
                if (match_q && (score_q != CW'(ROUNDS))) begin
                    score_d = score_q + 1'b1;
                end
                round_d = round_q + 1'b1;
                state_d = (round_q == CW'(ROUNDS - 1)) ? ST_DONE : ST_LOAD;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmp_num_1_o = target_q;
    assign cmp_num_2_o = guess_q;
    assign target_o    = target_q;
    assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_WAIT) ||
                         (state_q == ST_CHECK) || (state_q == ST_RESULT);
    assign hit_o       = hit_q;
    assign miss_o      = miss_q;
    assign score_o     = score_q;
    assign round_o     = round_q;
    assign game_over_o = (state_q == ST_DONE);
`ifdef GAME_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`endif

endmodule
